histogram_seq_ctrl: RTL and testbench
=====================================

HISTOGRAM_SEQ_CTRL -- requirements
Module: histogram_seq_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning bin address width (2^ADDR_W bins).
REQ-002 SHALL have parameter CNT_W, default 19, meaning bin counter width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset, with the following ports (clock and reset first):
- cam_clk  in  1  sole clock.
- rst_n  in  1  async active-low reset.
- cam_vsync  in  1  frame sync; falling edge = frame start, rising edge = frame end.
- cam_valid  in  1  pixel qualifier.
- cam_gray  in  ADDR_W  pixel gray value (bin index).
- hist_rd_en  out  1  histogram RAM read enable.
- hist_rd_addr  out  ADDR_W  histogram RAM read address.
- hist_rd_q  in  CNT_W  histogram RAM read data, 1-cycle latency, old data on read-during-write.
- hist_wr_en  out  1  histogram RAM write enable.
- hist_wr_addr  out  ADDR_W  histogram RAM write address.
- hist_wr_data  out  CNT_W  histogram RAM write data.
- disp_wr_en  out  1  display RAM write enable.
- disp_wr_addr  out  ADDR_W  display RAM write address.
- disp_wr_data  out  CNT_W  display RAM write data.
- busy  out  1  high in CLEAR, DRAIN, READOUT.
- frame_done  out  1  1-cycle pulse after last display write.
- frame_skip  out  1  1-cycle pulse when a frame start is ignored.

Function
REQ-004 SHALL implement FSM states CLEAR, WAIT, ACCUM, DRAIN, READOUT; reset state CLEAR.
REQ-005 SHALL detect vsync edges with one register on cam_vsync; the edge register resets to 0.
REQ-006 CLEAR: SHALL write 0 to addresses 0..2^ADDR_W-1, one per cycle, ascending; after the last address -> WAIT.
REQ-007 WAIT: SHALL go to ACCUM on a vsync falling edge; ignore cam_valid.
REQ-008 ACCUM: for cam_valid=1 in cycle t, SHALL assert hist_rd_en with hist_rd_addr=cam_gray in cycle t, then hist_wr_en in cycle t+1 with hist_wr_addr=that gray and hist_wr_data=base+1.
REQ-009 base SHALL be the previous cycle's hist_wr_data when hist_wr_en was high in the previous cycle at the same address (forwarding); otherwise hist_rd_q.
REQ-010 Increment SHALL saturate at 2^CNT_W-1 (no wrap).
REQ-011 ACCUM: on a vsync rising edge -> DRAIN; a cam_valid in that same cycle SHALL still be counted.
REQ-012 DRAIN: SHALL last 1 cycle, completing any in-flight write, then -> READOUT.
REQ-013 READOUT: SHALL read addresses 0..2^ADDR_W-1 ascending, one per cycle. Each read SHALL produce disp_wr_en one cycle later, with disp_wr_addr = read address and disp_wr_data = hist_rd_q.
REQ-014 After the last display write, SHALL pulse frame_done and go to CLEAR.
REQ-015 A vsync falling edge in CLEAR, DRAIN or READOUT SHALL pulse frame_skip, leave state unchanged, and leave that frame uncounted.
REQ-016 cam_valid outside ACCUM SHALL produce no RAM access.
REQ-017 Address counters SHALL wrap only via state exit; the counter SHALL be 0 on every state entry.
REQ-018 Outside the ACCUM, CLEAR and READOUT uses, hist_rd_en, hist_wr_en and disp_wr_en SHALL be 0; unused address/data outputs SHALL hold 0.

Reset
REQ-019 While rst_n=0, all outputs SHALL be 0 except busy=1 (state CLEAR); the FSM SHALL restart CLEAR at address 0 on release.
REQ-020 Reset asserted mid-READOUT or mid-ACCUM SHALL abort immediately with no further RAM writes; after release a full CLEAR SHALL precede any counting.

Verification
REQ-021 Release reset -> hist_wr_en=1 and hist_wr_data=0 for 256 consecutive cycles, addresses 0..255, then busy=0.
REQ-022 Frame with pixels 5,5,5 back-to-back plus 7 -> READOUT writes disp_wr_data=3 at addr 5, 1 at addr 7, 0 elsewhere.
REQ-023 Bin preloaded to 19'h7FFFF, then one more pixel to that bin -> the bin stays 19'h7FFFF.
REQ-024 vsync rising edge -> 1 DRAIN cycle, then 256 disp writes addressed 0..255, then a frame_done pulse, then 256 clear writes.
REQ-025 vsync falls during READOUT -> frame_skip pulses once, pixels of that frame are not counted, and the next falling edge after WAIT is accepted.
REQ-026 rst_n pulsed low at READOUT addr 100 -> disp_wr_en=0 immediately, then a full CLEAR sequence after release.

Source files
------------

// File: rtl/histogram_seq_ctrl_if.sv
// rtl/histogram_seq_ctrl_if.sv - histogram RAM and display RAM port bundle
interface histogram_seq_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 19
);
    logic              hist_rd_en;
    logic [ADDR_W-1:0] hist_rd_addr;
    logic [CNT_W-1:0]  hist_rd_q;
    logic              hist_wr_en;
    logic [ADDR_W-1:0] hist_wr_addr;
    logic [CNT_W-1:0]  hist_wr_data;
    logic              disp_wr_en;
    logic [ADDR_W-1:0] disp_wr_addr;
    logic [CNT_W-1:0]  disp_wr_data;

    modport master (
        output hist_rd_en,
        output hist_rd_addr,
        input  hist_rd_q,
        output hist_wr_en,
        output hist_wr_addr,
        output hist_wr_data,
        output disp_wr_en,
        output disp_wr_addr,
        output disp_wr_data
    );

    modport slave (
        input  hist_rd_en,
        input  hist_rd_addr,
        output hist_rd_q,
        input  hist_wr_en,
        input  hist_wr_addr,
        input  hist_wr_data,
        input  disp_wr_en,
        input  disp_wr_addr,
        input  disp_wr_data
    );
endinterface

// File: rtl/histogram_seq_ctrl.sv
// rtl/histogram_seq_ctrl.sv - per-frame gray histogram sequencer: clear, accumulate, drain, readout
module histogram_seq_ctrl #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 19
) (
    input  logic                 cam_clk,
    input  logic                 rst_n,
    input  logic                 cam_vsync,
    input  logic                 cam_valid,
    input  logic [ADDR_W-1:0]    cam_gray,
    histogram_seq_ctrl_if.master ram,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 frame_skip
);
    localparam int              NBINS   = 1 << ADDR_W;
    localparam int              CW      = ADDR_W + 1;
    localparam logic [CW-1:0]   LAST    = CW'(NBINS - 1);
    localparam logic [CW-1:0]   RO_END  = CW'(NBINS);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_CLEAR,
        S_WAIT,
        S_ACCUM,
        S_DRAIN,
        S_READOUT
    } state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic               skip;

    logic               vsync_q;
    logic               vs_fall, vs_rise;

    logic               acc_pix;
    logic               acc_wr;
    logic               pend_v;
    logic [ADDR_W-1:0]  pend_addr;
    logic               fwd_v;
    logic [ADDR_W-1:0]  fwd_addr;
    logic [CNT_W-1:0]   fwd_data;
    logic [CNT_W-1:0]   base;
    logic [CNT_W-1:0]   inc;

    logic               disp_v;
    logic [ADDR_W-1:0]  disp_addr;
    logic               done_q;

    assign vs_fall = vsync_q & ~cam_vsync;
    assign vs_rise = ~vsync_q & cam_vsync;

    assign acc_pix = (state == S_ACCUM) && cam_valid;
    assign acc_wr  = pend_v && ((state == S_ACCUM) || (state == S_DRAIN));

    // The RAM returns old data on read-during-write, so a back-to-back hit
    // on the same bin must take the value written in the previous cycle.
    assign base = (fwd_v && (fwd_addr == pend_addr)) ? fwd_data : ram.hist_rd_q;
    assign inc  = (base == CNT_MAX) ? CNT_MAX : base + CNT_W'(1);

    always_ff @(posedge cam_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        skip      = 1'b0;
        case (state)
            S_CLEAR: begin
                skip = vs_fall;
                if (cnt == LAST) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_WAIT: begin
                if (vs_fall) begin
                    state_nxt = S_ACCUM;
                    cnt_nxt   = '0;
                end
            end
            S_ACCUM: begin
                if (vs_rise) begin
                    state_nxt = S_DRAIN;
                    cnt_nxt   = '0;
                end
            end
            S_DRAIN: begin
                skip      = vs_fall;
                state_nxt = S_READOUT;
                cnt_nxt   = '0;
            end
            S_READOUT: begin
                skip = vs_fall;
                // One extra cycle past the last read lets the final display write land.
                if (cnt == RO_END) begin
                    state_nxt = S_CLEAR;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = S_CLEAR;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge cam_clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q   <= 1'b0;
            pend_v    <= 1'b0;
            pend_addr <= '0;
            fwd_v     <= 1'b0;
            fwd_addr  <= '0;
            fwd_data  <= '0;
            disp_v    <= 1'b0;
            disp_addr <= '0;
            done_q    <= 1'b0;
        end else begin
            vsync_q   <= cam_vsync;
            pend_v    <= acc_pix;
            pend_addr <= acc_pix ? cam_gray : '0;
            fwd_v     <= acc_wr;
            fwd_addr  <= acc_wr ? pend_addr : '0;
            fwd_data  <= acc_wr ? inc : '0;
            disp_v    <= (state == S_READOUT) && (cnt != RO_END);
            disp_addr <= ((state == S_READOUT) && (cnt != RO_END)) ? cnt[ADDR_W-1:0] : '0;
            done_q    <= (state == S_READOUT) && (cnt == RO_END);
        end
    end

    always_comb begin
        ram.hist_rd_en   = 1'b0;
        ram.hist_rd_addr = '0;
        ram.hist_wr_en   = 1'b0;
        ram.hist_wr_addr = '0;
        ram.hist_wr_data = '0;
        ram.disp_wr_en   = 1'b0;
        ram.disp_wr_addr = '0;
        ram.disp_wr_data = '0;
        busy             = (state != S_WAIT) && (state != S_ACCUM);
        frame_done       = done_q;
        frame_skip       = skip;

        case (state)
            S_CLEAR: begin
                ram.hist_wr_en   = 1'b1;
                ram.hist_wr_addr = cnt[ADDR_W-1:0];
            end
            S_ACCUM, S_DRAIN: begin
                if (acc_pix) begin
                    ram.hist_rd_en   = 1'b1;
                    ram.hist_rd_addr = cam_gray;
                end
                if (acc_wr) begin
                    ram.hist_wr_en   = 1'b1;
                    ram.hist_wr_addr = pend_addr;
                    ram.hist_wr_data = inc;
                end
            end
            S_READOUT: begin
                if (cnt != RO_END) begin
                    ram.hist_rd_en   = 1'b1;
                    ram.hist_rd_addr = cnt[ADDR_W-1:0];
                end
            end
            default: ;
        endcase

        if (disp_v) begin
            ram.disp_wr_en   = 1'b1;
            ram.disp_wr_addr = disp_addr;
            ram.disp_wr_data = ram.hist_rd_q;
        end

        // Reset must silence every strobe at once, even though the state already reads CLEAR.
        if (!rst_n) begin
            ram.hist_rd_en   = 1'b0;
            ram.hist_rd_addr = '0;
            ram.hist_wr_en   = 1'b0;
            ram.hist_wr_addr = '0;
            ram.hist_wr_data = '0;
            ram.disp_wr_en   = 1'b0;
            ram.disp_wr_addr = '0;
            ram.disp_wr_data = '0;
            busy             = 1'b1;
            frame_done       = 1'b0;
            frame_skip       = 1'b0;
        end
    end
endmodule

// File: tb/tb_histogram_seq_ctrl.sv
// tb/tb_histogram_seq_ctrl.sv - self-checking bench for histogram_seq_ctrl
module tb_histogram_seq_ctrl;
    localparam int ADDR_W = 8;
    localparam int CNT_W  = 19;
    localparam int NB     = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

    logic              cam_clk;
    logic              rst_n;
    logic              cam_vsync;
    logic              cam_valid;
    logic [ADDR_W-1:0] cam_gray;
    logic              busy;
    logic              frame_done;
    logic              frame_skip;

    histogram_seq_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) ram_if ();

    histogram_seq_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .cam_clk    (cam_clk),
        .rst_n      (rst_n),
        .cam_vsync  (cam_vsync),
        .cam_valid  (cam_valid),
        .cam_gray   (cam_gray),
        .ram        (ram_if),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_skip (frame_skip)
    );

    initial cam_clk = 1'b0;
    always #5 cam_clk = ~cam_clk;

    // Histogram RAM: 1-cycle read latency, old data on read-during-write.
    logic [CNT_W-1:0]  ram_mem [NB];
    logic [CNT_W-1:0]  rd_q;
    logic              poke_en;
    logic [ADDR_W-1:0] poke_addr;
    logic [CNT_W-1:0]  poke_data;

    always @(posedge cam_clk) begin
        if (ram_if.hist_rd_en) rd_q <= ram_mem[ram_if.hist_rd_addr];
        if (ram_if.hist_wr_en) ram_mem[ram_if.hist_wr_addr] <= ram_if.hist_wr_data;
        if (poke_en) ram_mem[poke_addr] <= poke_data;
    end
    assign ram_if.hist_rd_q = rd_q;

    typedef struct {
        int g0, g1, g2, g3;
        int n;
        int pa, ea;
        int pb, eb;
    } vec_t;

    vec_t             vecs [6];
    int               n_chk;
    int               n_pass;
    int               pix_q [$];
    int               ref_hist [NB];
    logic [CNT_W-1:0] disp_mem [NB];
    bit               ab;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge cam_clk);
        #1;
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (busy && c < 2000) begin
            @(negedge cam_clk);
            c++;
        end
        if (busy) check("idle_timeout", busy, 0);
        tick();
    endtask

    // Entered at a negedge sample; counts ascending zero writes until busy drops.
    task automatic collect_clear();
        int cnt, bad;
        cnt = 0;
        bad = 0;
        for (int c = 0; c < 400 && busy; c++) begin
            if (ram_if.hist_wr_en && ram_if.hist_wr_data == 0 && ram_if.hist_wr_addr == 8'(cnt)) cnt++;
            else bad++;
            @(negedge cam_clk);
        end
        check("clear_len", cnt, 256);
        check("clear_bad", bad, 0);
        check("idle_after_clear", busy, 0);
    endtask

    task automatic run_frame(input bit rise_last, input int skip_at, input int abort_at, output bit aborted);
        int  n, ord_bad, wr_bad, skips, rd_bad;
        bit  done, last_valid;
        aborted = 0;
        wait_idle();
        for (int b = 0; b < NB; b++) ref_hist[b] = 0;
        cam_vsync = 1'b0;
        tick();
        rd_bad = 0;
        last_valid = 0;
        for (int i = 0; i < pix_q.size(); i++) begin
            cam_valid = (pix_q[i] >= 0);
            cam_gray  = cam_valid ? 8'(pix_q[i]) : 8'($urandom);
            last_valid = cam_valid;
            if (rise_last && i == pix_q.size() - 1) cam_vsync = 1'b1;
            if (cam_valid) ref_hist[pix_q[i]]++;
            @(negedge cam_clk);
            if (ram_if.hist_rd_en !== cam_valid) rd_bad++;
            else if (cam_valid && ram_if.hist_rd_addr !== cam_gray) rd_bad++;
            else if (!cam_valid && ram_if.hist_rd_addr !== 8'd0) rd_bad++;
            tick();
        end
        if (!rise_last) begin
            cam_valid = 1'b0;
            cam_vsync = 1'b1;
            tick();
        end
        cam_valid = 1'b0;
        check("accum_rd", rd_bad, 0);
        @(negedge cam_clk);
        check("drain", {busy, ram_if.hist_rd_en, ram_if.disp_wr_en, ram_if.hist_wr_en},
              {1'b1, 1'b0, 1'b0, rise_last & last_valid});
        @(negedge cam_clk);
        check("readout_first", {ram_if.hist_rd_en, ram_if.hist_rd_addr}, {1'b1, 8'd0});

        n = 0; ord_bad = 0; wr_bad = 0; skips = 0; done = 0;
        for (int b = 0; b < NB; b++) disp_mem[b] = '0;
        for (int c = 0; c < 1200 && !done; c++) begin
            @(negedge cam_clk);
            if (frame_skip) skips++;
            if (frame_done) begin
                done = 1;
            end else begin
                if (ram_if.hist_wr_en) wr_bad++;
                if (ram_if.disp_wr_en) begin
                    if (ram_if.disp_wr_addr != 8'(n)) ord_bad++;
                    disp_mem[ram_if.disp_wr_addr] = ram_if.disp_wr_data;
                    n++;
                end
                if (abort_at >= 0 && ram_if.disp_wr_en && ram_if.disp_wr_addr == 8'(abort_at)) begin
                    rst_n = 1'b0;
                    #1;
                    check("abort_now", {ram_if.disp_wr_en, ram_if.hist_wr_en, ram_if.hist_rd_en, busy, frame_done},
                          5'b00010);
                    wr_bad = 0;
                    repeat (3) begin
                        @(negedge cam_clk);
                        if (ram_if.hist_wr_en || ram_if.disp_wr_en) wr_bad++;
                    end
                    check("abort_quiet", wr_bad, 0);
                    tick();
                    rst_n = 1'b1;
                    @(negedge cam_clk);
                    collect_clear();
                    aborted = 1;
                    return;
                end
                if (c == skip_at) begin
                    @(posedge cam_clk); #1;
                    cam_vsync = 1'b0;
                    cam_valid = 1'b1;
                    cam_gray  = 8'($urandom);
                end
                if (c == skip_at + 20) begin
                    @(posedge cam_clk); #1;
                    cam_vsync = 1'b1;
                    cam_valid = 1'b0;
                end
            end
        end
        check("ro_count", n, 256);
        check("ro_order", ord_bad, 0);
        check("ro_no_hist_wr", wr_bad, 0);
        check("frame_done", done, 1);
        check("skip_pulses", skips, (skip_at >= 0) ? 1 : 0);
        if (done) collect_clear();
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got time limit expected $finish");
        $fatal(1);
    end

    initial begin
        longint s;
        int     bad;
        n_chk = 0; n_pass = 0;
        rst_n = 1'b0; cam_vsync = 1'b1; cam_valid = 1'b0; cam_gray = '0;
        poke_en = 1'b0; poke_addr = '0; poke_data = '0;

        vecs[0] = '{5, 5, 5, 7, 4, 5, 3, 7, 1};
        vecs[1] = '{0, 0, 0, 0, 4, 0, 4, 1, 0};
        vecs[2] = '{255, 0, 255, 0, 4, 255, 2, 0, 2};
        vecs[3] = '{3, 4, 3, 4, 4, 3, 2, 4, 2};
        vecs[4] = '{200, 0, 0, 0, 1, 200, 1, 0, 0};
        vecs[5] = '{10, 10, 11, 10, 4, 10, 3, 11, 1};

        repeat (3) @(negedge cam_clk);
        check("reset_strobes", {ram_if.hist_rd_en, ram_if.hist_wr_en, ram_if.disp_wr_en, busy, frame_done, frame_skip},
              6'b000100);
        check("reset_buses", {ram_if.hist_rd_addr, ram_if.hist_wr_addr, ram_if.disp_wr_addr,
                              ram_if.hist_wr_data, ram_if.disp_wr_data}, 0);
        tick();
        rst_n = 1'b1;
        @(negedge cam_clk);
        collect_clear();

        for (int i = 0; i < 6; i++) begin
            pix_q.delete();
            pix_q.push_back(vecs[i].g0);
            if (vecs[i].n > 1) pix_q.push_back(vecs[i].g1);
            if (vecs[i].n > 2) pix_q.push_back(vecs[i].g2);
            if (vecs[i].n > 3) pix_q.push_back(vecs[i].g3);
            run_frame(i[0], -1, -1, ab);
            check($sformatf("vec%0d_bin_a", i), disp_mem[vecs[i].pa], vecs[i].ea);
            check($sformatf("vec%0d_bin_b", i), disp_mem[vecs[i].pb], vecs[i].eb);
            s = 0;
            for (int b = 0; b < NB; b++) s += disp_mem[b];
            check($sformatf("vec%0d_sum", i), s, vecs[i].n);
        end

        for (int f = 0; f < 4; f++) begin
            int len;
            pix_q.delete();
            len = $urandom_range(20, 60);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 9) < 3) pix_q.push_back(-1);
                else if (f < 2) pix_q.push_back($urandom_range(0, 5));
                else pix_q.push_back($urandom_range(0, 255));
            end
            run_frame(f[0], -1, -1, ab);
            bad = 0;
            for (int b = 0; b < NB; b++) begin
                if (longint'(disp_mem[b]) != ((ref_hist[b] > int'(CMAX)) ? longint'(CMAX) : longint'(ref_hist[b])))
                    bad++;
            end
            check($sformatf("rand%0d_bad_bins", f), bad, 0);
        end

        wait_idle();
        poke_en = 1'b1; poke_addr = 8'd9; poke_data = CMAX;
        tick();
        poke_addr = 8'd12; poke_data = CMAX - 1;
        tick();
        poke_en = 1'b0;
        pix_q = '{9, 12, 12, 12};
        run_frame(1'b1, -1, -1, ab);
        check("sat_single", disp_mem[9], CMAX);
        check("sat_forward", disp_mem[12], CMAX);

        pix_q = '{1, 2, 3};
        run_frame(1'b0, 50, -1, ab);
        pix_q = '{6, 6};
        run_frame(1'b0, -1, -1, ab);
        check("after_skip_bin6", disp_mem[6], 2);

        pix_q = '{4};
        run_frame(1'b0, -1, 100, ab);
        check("abort_taken", ab, 1);

        wait_idle();
        cam_vsync = 1'b0;
        tick();
        cam_valid = 1'b1; cam_gray = 8'd3;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("accum_reset", {ram_if.hist_wr_en, ram_if.hist_rd_en, busy}, 3'b001);
        tick();
        rst_n = 1'b1; cam_valid = 1'b0; cam_vsync = 1'b1;
        @(negedge cam_clk);
        collect_clear();
        pix_q = '{3};
        run_frame(1'b0, -1, -1, ab);
        check("post_reset_bin3", disp_mem[3], 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
